// File: rtl/game_sequencer.sv
// game_sequencer: brick-breaker round controller (attract, serve, play, ball-lost, win, lose).
// Define GAME_PAUSE_EN to build the PAUSE state driven by pause_sw.
module game_sequencer #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int LOST_FRAMES  = 30,
    parameter int SPEEDUP_HITS = 5,
    parameter int MAX_SPEED    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_sw,
    input  logic       vsync,
    input  logic       ball_lost,
    input  logic       block_hit,
    input  logic       all_cleared,
    output logic [2:0] state_o,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       frame_en,
    output logic [1:0] lives,
    output logic [1:0] speed_level,
    output logic       win,
    output logic       lose
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
    localparam int FCW        = $clog2(MAX_FRAMES) + 1;
    localparam int HCW        = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;

    localparam logic [FCW-1:0] SERVE_LAST = FCW'(SERVE_FRAMES - 1);
    localparam logic [FCW-1:0] LOST_LAST  = FCW'(LOST_FRAMES - 1);
    localparam logic [HCW-1:0] HIT_LAST   = HCW'(SPEEDUP_HITS - 1);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);
    localparam logic [1:0]     SPEED_MAX  = 2'(MAX_SPEED);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5,
        S_PAUSE = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic             start_q, vsync_q;
    logic [1:0]       lives_q, lives_d;
    logic [1:0]       speed_q, speed_d;
    logic [HCW-1:0]   hit_cnt_q, hit_cnt_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    logic             ball_run_q, ball_run_d;
    logic             ball_reset_q, ball_reset_d;
    logic             frame_en_q, frame_en_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;

    logic start_rise;
    logic frame_tick;
    logic play_active;

    assign start_rise = start & ~start_q;
    assign frame_tick = vsync & ~vsync_q;

    // State register and all datapath/output flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            vsync_q      <= 1'b0;
            lives_q      <= LIVES_INIT;
            speed_q      <= '0;
            hit_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b0;
            frame_en_q   <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the values from before this edge.
            state_q      <= state_d;
            start_q      <= start;
            vsync_q      <= vsync;
            lives_q      <= lives_d;
            speed_q      <= speed_d;
            hit_cnt_q    <= hit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            ball_run_q   <= ball_run_d;
            ball_reset_q <= ball_reset_d;
            frame_en_q   <= frame_en_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assign a default before the case so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) state_d = S_SERVE;
            end
            S_SERVE: begin
                if (start_rise || (frame_tick && frame_cnt_q == SERVE_LAST)) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (all_cleared) begin
                    state_d = S_WIN;
                end else if (ball_lost) begin
                    state_d = (lives_q == 2'd1) ? S_LOSE : S_LOST;
                end
`ifdef GAME_PAUSE_EN
                if (pause_sw) state_d = S_PAUSE;
`endif
            end
            S_LOST: begin
                if (frame_tick && frame_cnt_q == LOST_LAST) state_d = S_SERVE;
            end
            S_WIN, S_LOSE: begin
                if (start_rise) state_d = S_IDLE;
            end
            S_PAUSE: begin
`ifdef GAME_PAUSE_EN
                if (start_rise) begin
                    state_d = S_IDLE;
                end else if (!pause_sw) begin
                    state_d = S_PLAY;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifndef GAME_PAUSE_EN
    logic unused_pause_sw;
    assign unused_pause_sw = pause_sw;
`endif

    // A PLAY cycle that is leaving for PAUSE counts no events.
    assign play_active = (state_q == S_PLAY) && (state_d != S_PAUSE);

    // Datapath and registered-output logic, all keyed off the next state.
    always_comb begin
        lives_d      = lives_q;
        speed_d      = speed_q;
        hit_cnt_d    = hit_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        ball_reset_d = 1'b0;
        frame_en_d   = 1'b0;

        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (frame_tick && (state_q == S_SERVE || state_q == S_LOST)) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
        end

        if (play_active) begin
            frame_en_d = frame_tick;
            if (block_hit) begin
                if (hit_cnt_q == HIT_LAST) begin
                    hit_cnt_d = '0;
                    if (speed_q < SPEED_MAX) speed_d = speed_q + 2'd1;
                end else begin
                    hit_cnt_d = hit_cnt_q + HCW'(1);
                end
            end
            if (state_d == S_LOST || state_d == S_LOSE) lives_d = lives_q - 2'd1;
        end

        if (state_d == S_SERVE && state_q != S_SERVE) ball_reset_d = 1'b1;

        if (state_d == S_IDLE) begin
            lives_d   = LIVES_INIT;
            speed_d   = '0;
            hit_cnt_d = '0;
        end

        ball_run_d = (state_d == S_PLAY);
        win_d      = (state_d == S_WIN);
        lose_d     = (state_d == S_LOSE);
    end

    assign state_o     = state_q;
    assign ball_run    = ball_run_q;
    assign ball_reset  = ball_reset_q;
    assign frame_en    = frame_en_q;
    assign lives       = lives_q;
    assign speed_level = speed_q;
    assign win         = win_q;
    assign lose        = lose_q;

    // Structural invariants of the registered outputs.
    a_speed_sat: assert property (@(posedge clk) disable iff (!rst) speed_q <= SPEED_MAX);
    a_run_play:  assert property (@(posedge clk) disable iff (!rst) ball_run_q == (state_q == S_PLAY));
    a_win_state: assert property (@(posedge clk) disable iff (!rst) win_q == (state_q == S_WIN));
    a_lose_state: assert property (@(posedge clk) disable iff (!rst) lose_q == (state_q == S_LOSE));
    a_reset_serve: assert property (@(posedge clk) disable iff (!rst) ball_reset_q |-> state_q == S_SERVE);

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed walk-through plus randomized play of game_sequencer,
// checked every cycle against a rule-level reference model.
module tb_game_sequencer;

    localparam int LIVES        = 3;
    localparam int SERVE_FRAMES = 60;
    localparam int LOST_FRAMES  = 30;
    localparam int SPEEDUP_HITS = 5;
    localparam int MAX_SPEED    = 3;

    localparam int IDLE  = 0;
    localparam int SERVE = 1;
    localparam int PLAY  = 2;
    localparam int LOST  = 3;
    localparam int WIN   = 4;
    localparam int LOSE  = 5;
    localparam int PAUSE = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic pause_sw = 1'b0;
    logic vsync = 1'b0;
    logic ball_lost = 1'b0;
    logic block_hit = 1'b0;
    logic all_cleared = 1'b0;

    logic [2:0] state_o;
    logic       ball_run;
    logic       ball_reset;
    logic       frame_en;
    logic [1:0] lives;
    logic [1:0] speed_level;
    logic       win;
    logic       lose;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model: state and counters as plain integers.
    int m_state  = IDLE;
    int m_lives  = LIVES;
    int m_speed  = 0;
    int m_hits   = 0;
    int m_frames = 0;
    int m_respawn = 0;
    int m_frame_en = 0;
    int m_start_prev = 0;
    int m_vsync_prev = 0;

    game_sequencer #(
        .LIVES       (LIVES),
        .SERVE_FRAMES(SERVE_FRAMES),
        .LOST_FRAMES (LOST_FRAMES),
        .SPEEDUP_HITS(SPEEDUP_HITS),
        .MAX_SPEED   (MAX_SPEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause_sw   (pause_sw),
        .vsync      (vsync),
        .ball_lost  (ball_lost),
        .block_hit  (block_hit),
        .all_cleared(all_cleared),
        .state_o    (state_o),
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .frame_en   (frame_en),
        .lives      (lives),
        .speed_level(speed_level),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One clock of the game rules, applied to the inputs present at this edge.
    task automatic model_step();
        int rise;
        int tick;
        int nxt;
        if (!rst) begin
            m_state = IDLE; m_lives = LIVES; m_speed = 0; m_hits = 0; m_frames = 0;
            m_respawn = 0; m_frame_en = 0; m_start_prev = 0; m_vsync_prev = 0;
            return;
        end
        rise = (start && !m_start_prev) ? 1 : 0;
        tick = (vsync && !m_vsync_prev) ? 1 : 0;
        m_start_prev = int'(start);
        m_vsync_prev = int'(vsync);
        nxt = m_state;
        m_respawn = 0;
        m_frame_en = 0;
        case (m_state)
            IDLE: if (rise != 0) nxt = SERVE;
            SERVE: begin
                m_frames += tick;
                if (rise != 0 || m_frames == SERVE_FRAMES) nxt = PLAY;
            end
            PLAY: begin
`ifdef GAME_PAUSE_EN
                if (pause_sw) nxt = PAUSE;
                else begin
`endif
                m_frame_en = tick;
                if (block_hit) begin
                    m_hits++;
                    if (m_hits == SPEEDUP_HITS) begin
                        m_hits = 0;
                        if (m_speed < MAX_SPEED) m_speed++;
                    end
                end
                if (all_cleared) nxt = WIN;
                else if (ball_lost) begin
                    m_lives--;
                    nxt = (m_lives == 0) ? LOSE : LOST;
                end
`ifdef GAME_PAUSE_EN
                end
`endif
            end
            LOST: begin
                m_frames += tick;
                if (m_frames == LOST_FRAMES) nxt = SERVE;
            end
            WIN, LOSE: if (rise != 0) nxt = IDLE;
            PAUSE: begin
                if (rise != 0) nxt = IDLE;
                else if (!pause_sw) nxt = PLAY;
            end
            default: nxt = IDLE;
        endcase
        if (nxt == SERVE && m_state != SERVE) m_respawn = 1;
        if (nxt != m_state) m_frames = 0;
        if (nxt == IDLE) begin
            m_lives = LIVES; m_speed = 0; m_hits = 0;
        end
        m_state = nxt;
    endtask

    task automatic compare_all();
        check("state_o", 32'(state_o), 32'(m_state));
        check("ball_run", 32'(ball_run), 32'(m_state == PLAY));
        check("ball_reset", 32'(ball_reset), 32'(m_respawn));
        check("frame_en", 32'(frame_en), 32'(m_frame_en));
        check("lives", 32'(lives), 32'(m_lives));
        check("speed_level", 32'(speed_level), 32'(m_speed));
        check("win", 32'(win), 32'(m_state == WIN));
        check("lose", 32'(lose), 32'(m_state == LOSE));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle();
        start = 1'b0; cycle();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1; cycle();
            vsync = 1'b0; cycle();
        end
    endtask

    initial begin
        // Reset held for two edges.
        rst = 1'b0;
        cycles(2);
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_lives", 32'(lives), 32'(LIVES));
        check("rst_run", 32'(ball_run), 32'd0);
        rst = 1'b1;
        cycle();

        // Launch: respawn pulse for exactly one cycle, then auto-launch after the serve frames.
        start = 1'b1; cycle();
        check("serve_entry", 32'(state_o), 32'(SERVE));
        check("serve_respawn", 32'(ball_reset), 32'd1);
        start = 1'b0; cycle();
        check("respawn_one_cycle", 32'(ball_reset), 32'd0);
        frames(SERVE_FRAMES);
        check("auto_launch", 32'(state_o), 32'(PLAY));
        check("auto_launch_run", 32'(ball_run), 32'd1);

        // Speed saturation after 16 hits.
        for (int i = 0; i < 16; i++) begin
            block_hit = 1'b1; cycle();
            block_hit = 1'b0; cycle();
        end
        check("speed_sat", 32'(speed_level), 32'(MAX_SPEED));

        // Lose all balls; speed survives each loss.
        for (int k = 0; k < LIVES; k++) begin
            ball_lost = 1'b1; cycle();
            ball_lost = 1'b0;
            check("lives_after_loss", 32'(lives), 32'(LIVES - 1 - k));
            check("speed_kept", 32'(speed_level), 32'(MAX_SPEED));
            if (k < LIVES - 1) begin
                frames(LOST_FRAMES);
                check("lost_to_serve", 32'(state_o), 32'(SERVE));
                frames(SERVE_FRAMES);
                check("serve_to_play", 32'(state_o), 32'(PLAY));
            end
        end
        check("game_over", 32'(state_o), 32'(LOSE));
        check("game_over_lose", 32'(lose), 32'd1);
        cycles(3);
        pulse_start();
        check("restart_idle", 32'(state_o), 32'(IDLE));
        check("restart_lives", 32'(lives), 32'(LIVES));

        // Early launch, then clear and lose the ball in the same cycle: win takes priority.
        pulse_start();
        pulse_start();
        check("early_launch", 32'(state_o), 32'(PLAY));
        all_cleared = 1'b1; ball_lost = 1'b1; cycle();
        all_cleared = 1'b0; ball_lost = 1'b0;
        check("win_priority", 32'(state_o), 32'(WIN));
        check("win_level", 32'(win), 32'd1);
        check("win_lives", 32'(lives), 32'(LIVES));
        ball_lost = 1'b1; block_hit = 1'b1; cycle();
        ball_lost = 1'b0; block_hit = 1'b0; cycle();
        pulse_start();
        check("win_restart", 32'(state_o), 32'(IDLE));

`ifdef GAME_PAUSE_EN
        pulse_start();
        pulse_start();
        pause_sw = 1'b1; cycle();
        check("pause_enter", 32'(state_o), 32'(PAUSE));
        check("pause_run", 32'(ball_run), 32'd0);
        ball_lost = 1'b1; cycle();
        ball_lost = 1'b0; cycle();
        check("pause_lives", 32'(lives), 32'(LIVES));
        pause_sw = 1'b0; cycle();
        check("pause_exit", 32'(state_o), 32'(PLAY));
        pulse_start();
`endif

        // Randomized play: sparse events, random vsync levels, rare resets.
        for (int i = 0; i < 25000; i++) begin
            vsync       = ($urandom_range(0, 2) == 0);
            block_hit   = ($urandom_range(0, 7) == 0);
            ball_lost   = ($urandom_range(0, 119) == 0);
            all_cleared = ($urandom_range(0, 799) == 0);
            start       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) pause_sw = ~pause_sw;
            rst         = ($urandom_range(0, 3999) != 0);
            cycle();
        end
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
